// File: rtl/nibble_src_pkg.sv
// nibble_src_pkg
// Shared definitions for the nibble stimulus source:
//   state_t  - auto-count FSM state (ST_HOLD, ST_COUNT)
//   VALUE_W  - width of the displayed value
//   KEY_REL  - level of a released (active-low) pushbutton
package nibble_src_pkg;

    typedef enum logic {
        ST_HOLD  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam int   VALUE_W = 4;
    localparam logic KEY_REL = 1'b1;

endpackage

// File: rtl/key_conditioner.sv
// key_conditioner
// Turns a raw active-low pushbutton into a one-cycle press pulse:
// 2-FF synchronizer -> optional stability debouncer -> falling-edge detect.
// Optional feature macro: NIBBLE_SRC_DEBOUNCE_EN (includes the DEB_CYCLES
// stability counter; without it the synchronized level goes straight to the
// edge detector).
// Ports:
//   clk    in  1  clock, rising edge
//   rst    in  1  synchronous active-high reset
//   key_n  in  1  raw pushbutton, active-low, asynchronous
//   press  out 1  one-cycle pulse per accepted press (release gives none)
module key_conditioner
    import nibble_src_pkg::*;
#(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic       prev;
    logic       armed;
    logic [1:0] primed;

    // primed[1] is set once sync2 holds a genuinely sampled key level rather
    // than its reset value. The detector only arms after it has seen the key
    // really released, so a key held through reset never yields a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= KEY_REL;
            sync2  <= KEY_REL;
            prev   <= KEY_REL;
            armed  <= 1'b0;
            primed <= 2'b00;
        end else begin
            sync1  <= key_n;
            sync2  <= sync1;
            prev   <= level;
            primed <= {primed[0], 1'b1};
            if (primed[1] && (sync2 == KEY_REL)) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef NIBBLE_SRC_DEBOUNCE_EN
    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          deb;

    // cnt counts consecutive cycles the synchronized level differs from the
    // accepted level; any return to the accepted level restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            deb <= KEY_REL;
        end else if (sync2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            deb <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = deb;
`else
    assign level = sync2;

    // DEB_CYCLES has no effect in this build; the empty block keeps the
    // parameter referenced.
    if (DEB_CYCLES < 1) begin : g_deb_cycles_illegal
    end
`endif

    assign press = armed && (prev == KEY_REL) && (level != KEY_REL);

endmodule

// File: rtl/nibble_count_source.sv
// nibble_count_source
// 4-bit stimulus source for the two-digit display stage. VALUE steps on
// debounced key presses (ST_HOLD), free-runs at one step per TICK_DIV cycles
// (ST_COUNT), or follows LOAD_VAL while LOAD is high.
// Priority each cycle: RESET > LOAD > state action. Arithmetic is modulo 16.
// Optional feature macro: NIBBLE_SRC_DEBOUNCE_EN (see key_conditioner).
// Ports:
//   CLOCK_50  in  1  sole clock, rising edge
//   RESET     in  1  synchronous active-high reset
//   KEY_UP_N  in  1  pushbutton, active-low, step +1
//   KEY_DN_N  in  1  pushbutton, active-low, step -1
//   LOAD      in  1  switch, level: VALUE follows LOAD_VAL while high
//   RUN       in  1  switch: 1 selects auto-count
//   DIR       in  1  switch: 1 counts up, 0 counts down
//   LOAD_VAL  in  4  switches, load data
//   VALUE     out 4  registered value to the display stage
//   TICK      out 1  registered one-cycle pulse on each prescaler wrap
//   state_dbg out 1  current FSM state, for observation only
module nibble_count_source
    import nibble_src_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               KEY_UP_N,
    input  logic               KEY_DN_N,
    input  logic               LOAD,
    input  logic               RUN,
    input  logic               DIR,
    input  logic [VALUE_W-1:0] LOAD_VAL,
    output logic [VALUE_W-1:0] VALUE,
    output logic               TICK,
    output state_t             state_dbg
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic               up_press;
    logic               dn_press;
    logic               load_m, load_s;
    logic               run_m, run_s;
    logic               dir_m, dir_s;
    logic [VALUE_W-1:0] lv_m, lv_s;
    state_t             state, state_nx;
    logic [PW-1:0]      presc, presc_nx;
    logic [VALUE_W-1:0] value, value_nx;
    logic               tick, tick_nx;

    key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key_up (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .key_n (KEY_UP_N),
        .press (up_press)
    );

    key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key_dn (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .key_n (KEY_DN_N),
        .press (dn_press)
    );

    // Switch synchronizers: no debouncing on switches.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            load_m <= 1'b0;
            load_s <= 1'b0;
            run_m  <= 1'b0;
            run_s  <= 1'b0;
            dir_m  <= 1'b0;
            dir_s  <= 1'b0;
            lv_m   <= '0;
            lv_s   <= '0;
        end else begin
            load_m <= LOAD;
            load_s <= load_m;
            run_m  <= RUN;
            run_s  <= run_m;
            dir_m  <= DIR;
            dir_s  <= dir_m;
            lv_m   <= LOAD_VAL;
            lv_s   <= lv_m;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= ST_HOLD;
            presc <= '0;
            value <= '0;
            tick  <= 1'b0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            value <= value_nx;
            tick  <= tick_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_HOLD:  if (run_s)  state_nx = ST_COUNT;
            ST_COUNT: if (!run_s) state_nx = ST_HOLD;
            default:  state_nx = ST_HOLD;
        endcase
    end

    // The prescaler defaults to 0, so it is held at 0 in ST_HOLD and under
    // LOAD, and is already 0 on the cycle ST_COUNT is entered. Key pulses are
    // single-cycle, so ignoring them outside ST_HOLD discards them.
    always_comb begin
        presc_nx = '0;
        value_nx = value;
        tick_nx  = 1'b0;
        if (load_s) begin
            value_nx = lv_s;
        end else if (state == ST_COUNT) begin
            if (presc == PRESC_LAST) begin
                tick_nx  = 1'b1;
                value_nx = dir_s ? value + 1'b1 : value - 1'b1;
            end else begin
                presc_nx = presc + 1'b1;
            end
        end else begin
            if (up_press && !dn_press) begin
                value_nx = value + 1'b1;
            end else if (dn_press && !up_press) begin
                value_nx = value - 1'b1;
            end
        end
    end

    assign VALUE     = value;
    assign TICK      = tick;
    assign state_dbg = state;

endmodule

// File: doc/nibble_count_source.md
# nibble_count_source

Sequential stimulus source for the two-digit display stage: produces the 4-bit value that the comparator/mux/seven-segment path turns into HEX1/HEX0. The value changes in one of three ways: by a debounced pushbutton step up or down, by loading from the switches, or by free-running count at a prescaled tick rate. The block sits directly upstream of the display stage. VALUE connects straight to that stage's 4-bit input in place of SW[3:0].

## Interface
- TICK_DIV, default 50_000_000: clock cycles per auto-count tick (1 Hz at 50 MHz); legal values ≥ 2.
- DEB_CYCLES, default 500_000: consecutive stable cycles required to accept a key level (10 ms); legal values ≥ 1.
- CLOCK_50  in  1  sole clock. All logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- KEY_UP_N  in  1  pushbutton, active-low, asynchronous; step +1.
- KEY_DN_N  in  1  pushbutton, active-low, asynchronous; step −1.
- LOAD  in  1  switch, asynchronous, level; while high, VALUE follows LOAD_VAL.
- RUN  in  1  switch, asynchronous; high selects auto-count.
- DIR  in  1  switch, asynchronous; 1 = count up, 0 = count down.
- LOAD_VAL  in  4  switches, asynchronous; load data.
- VALUE  out  4  registered value fed to the display stage.
- TICK  out  1  one-cycle pulse on each prescaler wrap while counting.

## Operation
- All asynchronous inputs pass through a 2-FF synchronizer. Reset state is 1 for keys and 0 for the switches.
- Key conditioning: synchronized level → debouncer → falling-edge detect → one-cycle press pulse. A release produces no pulse.
- FSM states: ST_HOLD and ST_COUNT.
  - ST_HOLD → ST_COUNT when synchronized RUN = 1.
  - ST_COUNT → ST_HOLD when synchronized RUN = 0.
- Prescaler:
  - Counts 0..TICK_DIV−1 only in ST_COUNT.
  - Is held at 0 in ST_HOLD.
  - Is cleared on the cycle of entry to ST_COUNT.
  - TICK is asserted when the prescaler equals TICK_DIV−1.
- Per-cycle priority: RESET > LOAD > state action.
  - ST_HOLD: an up press steps +1 and a down press steps −1. Both pulses in the same cycle leave VALUE unchanged.
  - ST_COUNT: on TICK, VALUE steps ±1 per DIR. Key presses are discarded.
- Arithmetic is modulo 16: 15+1 → 0, 0−1 → 15. Values 10..15 are legal and pass unmodified; the display stage handles them.
- LOAD high:
  - VALUE ← synchronized LOAD_VAL every cycle.
  - The prescaler is forced to 0 and TICK is forced to 0.
  - Key pulses are discarded.
- RESET, including mid-press or mid-count:
  - VALUE = 0, TICK = 0, state ST_HOLD, prescaler 0.
  - Debounced key state = released, debounce counters 0, synchronizers at reset values.
  - A key held through reset release produces no press pulse until it is released and pressed again.

## Timing
- VALUE and TICK are registered outputs with no combinational path from inputs.
- Key press, with DEBOUNCE_EN, key held low continuously: VALUE updates on the (DEB_CYCLES+3)th rising edge after the first edge that samples the key low.
  - Any bounce back high before acceptance restarts the count.
- Key press, without DEBOUNCE_EN: VALUE updates on the 3rd edge.
- LOAD: VALUE reflects LOAD_VAL on the 3rd edge after LOAD/LOAD_VAL settle.
- RUN: the first auto step occurs TICK_DIV edges after entry to ST_COUNT. Entry happens on the 3rd edge after RUN rises.
- TICK and the step register on the same edge. TICK is high for exactly one cycle per TICK_DIV cycles.

## Configuration
- NIBBLE_SRC_DEBOUNCE_EN defined: the DEB_CYCLES stability counter is included in each key path.
- Not defined:
  - The synchronized level feeds the edge detector directly.
  - DEB_CYCLES is ignored.
  - No counter logic is synthesized.
- Switch inputs are never debounced; this holds in both builds.

## Structure
- Package nibble_src_pkg holds:
  - the state type (ST_HOLD, ST_COUNT);
  - VALUE_W = 4;
  - the key released level KEY_REL = 1'b1.
- Sub-module key_conditioner (synchronizer, optional debouncer, edge detect → press pulse) is instantiated twice, once per key.
- Prescaler, FSM and value register live in the top module.

## Test plan
Bench parameters: TICK_DIV = 4, DEB_CYCLES = 3, macro defined unless stated otherwise.
- **Reset:** assert RESET for 2 cycles with all keys low → VALUE = 0, TICK = 0; no step after release until the keys are released and pressed again.
- **Clean up press:** hold KEY_UP_N low 10 cycles from VALUE = 7 → VALUE = 8 on edge 6 and stays 8; repeat at 15 → 0.
- **Bounce:** KEY_DN_N pattern low, high, low×8 from VALUE = 0 → exactly one step to 15, at edge 6 after the final low run starts. Without the macro, the same stimulus yields two steps.
- **Auto-count:** RUN = 1, DIR = 0 from VALUE = 2 → TICK every 4 cycles; VALUE 1, 0, 15, 14; up presses ignored.
- **Load:** during auto-count, LOAD = 1 with LOAD_VAL = 9 → VALUE = 9 with no TICK while LOAD is high; after LOAD falls, the first step to 10 (DIR = 1) comes 4 cycles later.
- **Simultaneous presses:** up and down pulses in the same cycle in ST_HOLD → VALUE unchanged.
